// File: rtl/div_unit.sv
// Iterative signed divider: one restoring step per clock on magnitudes, with the
// signs applied at the end. It reports a one-cycle ready strobe.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int             CW        = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_STEP = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t state, state_next;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] abs_b;
    logic [WIDTH:0]   rem;
    logic             sign_a;
    logic             sign_b;
    logic             overflow;
    logic             zero_pending;

    logic [WIDTH-1:0] abs_a_in;
    logic [WIDTH-1:0] abs_b_in;
    logic             b_zero_in;
    logic             overflow_in;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_step;
    logic [WIDTH-1:0] quo_step;
    logic             fit;

    logic             do_step;
    logic             finish_normal;
    logic             finish_zero;
    logic [WIDTH-1:0] result_next;
    logic [WIDTH-1:0] remainder_next;
    logic             exception_next;
    logic             ready_next;
    logic             busy_next;

    // MIN_INT negates to itself, which read as unsigned is exactly its magnitude.
    assign abs_a_in    = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign abs_b_in    = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
    assign b_zero_in   = (data_operandB == '0);
    assign overflow_in = (data_operandA == MIN_INT) && (data_operandB == '1);

    assign rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
    assign fit       = (rem_shift >= {1'b0, abs_b});
    assign rem_step  = fit ? (rem_shift - {1'b0, abs_b}) : rem_shift;
    assign quo_step  = {quo[WIDTH-2:0], fit};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (ctrl_DIV) begin
            state_next = b_zero_in ? DONE : RUN;
        end else begin
            case (state)
                IDLE: state_next = IDLE;
                RUN:  state_next = (count == LAST_STEP) ? FIX : RUN;
                FIX:  state_next = DONE;
                DONE: state_next = zero_pending ? DONE : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // A start pulse in any state wins, so an aborted operation never completes.
    always_comb begin
        do_step        = (state == RUN) && !ctrl_DIV;
        finish_normal  = (state == FIX) && !ctrl_DIV;
        finish_zero    = (state == DONE) && zero_pending && !ctrl_DIV;
        result_next    = data_result;
        remainder_next = data_remainder;
        exception_next = data_exception;
        ready_next     = 1'b0;
        busy_next      = busy;
        if (ctrl_DIV) begin
            busy_next = 1'b1;
        end else if (finish_normal) begin
            result_next    = (sign_a ^ sign_b) ? -quo : quo;
            remainder_next = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            exception_next = overflow;
            ready_next     = 1'b1;
            busy_next      = 1'b0;
        end else if (finish_zero) begin
            result_next    = '0;
            remainder_next = '0;
            exception_next = 1'b1;
            ready_next     = 1'b1;
            busy_next      = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count        <= '0;
            quo          <= '0;
            abs_b        <= '0;
            rem          <= '0;
            sign_a       <= 1'b0;
            sign_b       <= 1'b0;
            overflow     <= 1'b0;
            zero_pending <= 1'b0;
        end else if (ctrl_DIV) begin
            count        <= '0;
            quo          <= abs_a_in;
            abs_b        <= abs_b_in;
            rem          <= '0;
            sign_a       <= data_operandA[WIDTH-1];
            sign_b       <= data_operandB[WIDTH-1];
            overflow     <= overflow_in;
            zero_pending <= b_zero_in;
        end else begin
            if (do_step) begin
                rem   <= rem_step;
                quo   <= quo_step;
                count <= count + CW'(1);
            end
            if (finish_zero) begin
                zero_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
        end else begin
            data_result    <= result_next;
            data_remainder <= remainder_next;
            data_exception <= exception_next;
            data_resultRDY <= ready_next;
            busy           <= busy_next;
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Testbench for div_unit: directed operations plus random operand pairs. Results
// are compared against a wide-integer reference model.
module tb_div_unit;
    logic        clock;
    logic        reset;
    logic        ctrl_DIV;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic [31:0] data_result;
    logic [31:0] data_remainder;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int checks;
    int errors;
    int strobes;

    div_unit #(.WIDTH(32)) dut (
        .clock(clock),
        .reset(reset),
        .ctrl_DIV(ctrl_DIV),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .data_result(data_result),
        .data_remainder(data_remainder),
        .data_exception(data_exception),
        .data_resultRDY(data_resultRDY),
        .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial strobes = 0;
    always @(negedge clock) begin
        if (data_resultRDY) strobes <= strobes + 1;
    end

    function automatic void refDiv(input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r,
                                   output logic e);
        longint la;
        longint lb;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
            e = 1'b1;
        end else begin
            q = 32'(la / lb);
            r = 32'(la % lb);
            e = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        data_operandA = a;
        data_operandB = b;
        ctrl_DIV = 1'b1;
        @(negedge clock);
        ctrl_DIV = 1'b0;
    endtask

    task automatic waitReady(output int cyc);
        cyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock);
            #1;
            cyc++;
            if (data_resultRDY) break;
        end
    endtask

    task automatic runOp(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eq, input logic [31:0] er, input logic ee,
                         input int ecyc);
        int cyc;
        applyStimulus(a, b);
        checkOutput({tag, "/busy_start"}, 32'(busy), 32'd1);
        waitReady(cyc);
        checkOutput({tag, "/latency"}, 32'(cyc), 32'(ecyc));
        checkOutput({tag, "/result"}, data_result, eq);
        checkOutput({tag, "/remainder"}, data_remainder, er);
        checkOutput({tag, "/exception"}, 32'(data_exception), 32'(ee));
        checkOutput({tag, "/busy_ready"}, 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        checkOutput({tag, "/rdy_drop"}, 32'(data_resultRDY), 32'd0);
        checkOutput({tag, "/busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        e;
        int          s0;
        int          cyc;

        checks = 0;
        errors = 0;
        reset = 1'b1;
        ctrl_DIV = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        #12;
        checkOutput("reset/result", data_result, 32'd0);
        checkOutput("reset/remainder", data_remainder, 32'd0);
        checkOutput("reset/exception", 32'(data_exception), 32'd0);
        checkOutput("reset/rdy", 32'(data_resultRDY), 32'd0);
        checkOutput("reset/busy", 32'(busy), 32'd0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed operations");
        runOp("unsigned", 32'd5184, 32'd1646, 32'd3, 32'd246, 1'b0, 33);
        runOp("neg_a", 32'(-817648), 32'd267482, 32'hFFFF_FFFD, 32'(-15202), 1'b0, 33);
        runOp("neg_b", 32'd817648, 32'(-267482), 32'hFFFF_FFFD, 32'd15202, 1'b0, 33);
        runOp("neg_ab", 32'(-8472456), 32'(-783424), 32'd10, 32'(-638216), 1'b0, 33);
        runOp("div_zero", 32'd783424, 32'd0, 32'd0, 32'd0, 1'b1, 1);
        runOp("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b1, 33);
        runOp("after_exc", 32'd7, 32'd2, 32'd3, 32'd1, 1'b0, 33);

        $display("[TB] restart while busy");
        s0 = strobes;
        applyStimulus(32'd100, 32'd7);
        repeat (8) @(negedge clock);
        applyStimulus(32'd1646, 32'd5184);
        waitReady(cyc);
        checkOutput("restart/latency", 32'(cyc), 32'd33);
        checkOutput("restart/result", data_result, 32'd0);
        checkOutput("restart/remainder", data_remainder, 32'd1646);
        repeat (3) @(negedge clock);
        checkOutput("restart/strobes", 32'(strobes - s0), 32'd1);

        $display("[TB] reset mid-operation");
        s0 = strobes;
        applyStimulus(32'd9172936, 32'd3);
        repeat (15) @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("midreset/result", data_result, 32'd0);
        checkOutput("midreset/remainder", data_remainder, 32'd0);
        checkOutput("midreset/exception", 32'(data_exception), 32'd0);
        checkOutput("midreset/rdy", 32'(data_resultRDY), 32'd0);
        checkOutput("midreset/busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (40) @(negedge clock);
        checkOutput("midreset/strobes", 32'(strobes - s0), 32'd0);
        runOp("post_reset", 32'd9172936, 32'd3, 32'd3057645, 32'd1, 1'b0, 33);

        $display("[TB] hold without start");
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            data_operandA = $urandom;
            data_operandB = $urandom;
            @(posedge clock);
            #1;
            checkOutput("hold/result", data_result, 32'd3057645);
            checkOutput("hold/remainder", data_remainder, 32'd1);
            checkOutput("hold/exception", 32'(data_exception), 32'd0);
            checkOutput("hold/rdy", 32'(data_resultRDY), 32'd0);
            checkOutput("hold/busy", 32'(busy), 32'd0);
        end

        $display("[TB] random operations");
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 6 == 0) b = 32'd0;
            else if (i % 6 == 1) b = 32'($urandom_range(1, 15));
            else if (i % 6 == 2) b = -32'($urandom_range(1, 15));
            if (i % 8 == 3) a = 32'h8000_0000;
            if (i % 8 == 5) a = 32'($urandom_range(0, 1000));
            refDiv(a, b, q, r, e);
            runOp($sformatf("rand%0d", i), a, b, q, r, e, (b == 32'd0) ? 1 : 33);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
